// File: rtl/rx_demap_data_provider.sv
// rx_demap_data_provider
//   Captures FFT output symbols into a two-bank (ping-pong) symbol buffer and
//   streams the occupied subcarriers to the equalizer/soft-demapper. Output
//   order is natural frequency order with DC removed: the negative-frequency
//   half first, then the positive half. Each output carries a pilot flag.
//
// Ports
//   i_clk, i_rst_n             clock, asynchronous active-low reset
//   i_fft_valid, i_fft_sop     one FFT bin per valid cycle; sop marks bin 0
//   i_fft_re, i_fft_im         FFT bin value (FFT order, bin 0 = DC)
//   i_pilot_offset             pilot phase, sampled when a symbol read starts
//   i_ready                    downstream accept
//   o_valid, o_re, o_im        output subcarrier
//   o_sc_idx                   subcarrier index j (0..NUSED-1)
//   o_is_pilot                 (j mod PILOT_SPACING) == sampled offset
//   o_last                     j == NUSED-1
//   o_overflow                 one-cycle pulse when an incoming symbol is dropped
//   o_dbg_state                read FSM state (0 = R_IDLE, 1 = R_RUN)
//
// Handshake: a sample transfers on any rising edge where o_valid & i_ready.
// While o_valid is high and i_ready low, every output field holds stable and
// o_valid stays high until the transfer happens.
module rx_demap_data_provider #(
  parameter int NFFT          = 128,
  parameter int NUSED         = 72,
  parameter int DW            = 16,
  parameter int PILOT_SPACING = 6,
  localparam int AW = $clog2(NFFT),
  localparam int JW = $clog2(NUSED),
  localparam int PW = (PILOT_SPACING > 1) ? $clog2(PILOT_SPACING) : 1
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_fft_valid,
  input  logic          i_fft_sop,
  input  logic [DW-1:0] i_fft_re,
  input  logic [DW-1:0] i_fft_im,
  input  logic [PW-1:0] i_pilot_offset,
  input  logic          i_ready,
  output logic          o_valid,
  output logic [DW-1:0] o_re,
  output logic [DW-1:0] o_im,
  output logic [JW-1:0] o_sc_idx,
  output logic          o_is_pilot,
  output logic          o_last,
  output logic          o_overflow,
  output logic          o_dbg_state
);

  typedef enum logic [0:0] {R_IDLE = 1'b0, R_RUN = 1'b1} rd_state_t;

  rd_state_t       state;
  logic [2*DW-1:0] mem [2*NFFT];
  logic [1:0]      full;
  logic [1:0]      full_next;

  // write side
  logic            wb;
  logic [AW-1:0]   wa;
  logic            drop;
  logic [AW-1:0]   w_addr;
  logic            w_first;
  logic            w_end;
  logic            bank_busy;
  logic            drop_now;
  logic            mem_we;
  logic            set_full;

  // read side
  logic            rb;
  logic            nrb;
  logic [JW-1:0]   rj;
  logic [PW-1:0]   pc;
  logic [PW-1:0]   off;
  logic            done;
  logic            load_ok;
  logic            rel;
  logic            restart;
  logic [JW-1:0]   rd_j;
  logic            rd_bank;
  logic [AW-1:0]   rd_bin;
  logic [2*DW-1:0] rd_data;

  function automatic logic [PW-1:0] pc_inc(input logic [PW-1:0] p);
    return (p == PW'(PILOT_SPACING - 1)) ? '0 : p + 1'b1;
  endfunction

  assign o_dbg_state = (state == R_RUN);

  // ---------------- write side ----------------
  assign nrb     = ~rb;
  assign load_ok = !o_valid || i_ready;
  // Reader releases its bank when the last subcarrier is accepted.
  assign rel     = (state == R_RUN) && o_valid && i_ready && o_last;
  assign restart = rel && full[nrb];

  // sop forces address 0 so a partial symbol is simply overwritten.
  assign w_addr    = i_fft_sop ? '0 : wa;
  assign w_first   = (w_addr == '0);
  assign w_end     = (w_addr == AW'(NFFT - 1));
  // A bank released by the reader on this same edge counts as free.
  assign bank_busy = full[wb] && !(rel && (rb == wb));
  // Drop decision is made on the first sample and held for the symbol.
  assign drop_now  = w_first ? bank_busy : drop;
  assign mem_we    = i_fft_valid && !drop_now;
  assign set_full  = mem_we && w_end;

  always_comb begin
    full_next = full;
    if (rel)      full_next[rb] = 1'b0;
    if (set_full) full_next[wb] = 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (mem_we) mem[{wb, w_addr}] <= {i_fft_re, i_fft_im};
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wa         <= '0;
      wb         <= 1'b0;
      drop       <= 1'b0;
      full       <= '0;
      o_overflow <= 1'b0;
    end else begin
      o_overflow <= i_fft_valid && w_first && bank_busy;
      full       <= full_next;
      if (i_fft_valid) begin
        drop <= drop_now;
        if (w_end) begin
          wa <= '0;
          if (!drop_now) wb <= ~wb;
        end else begin
          wa <= w_addr + 1'b1;
        end
      end
    end
  end

  // ---------------- read side ----------------
  // On a back-to-back restart the next bank's j=0 is fetched on the same
  // edge that accepts the previous o_last, so the stream has no bubble.
  always_comb begin
    rd_j    = restart ? '0 : rj;
    rd_bank = restart ? nrb : rb;
    if (rd_j < JW'(NUSED / 2)) rd_bin = AW'(NFFT - NUSED / 2) + AW'(rd_j);
    else                       rd_bin = AW'(rd_j) - AW'(NUSED / 2 - 1);
  end

  assign rd_data = mem[{rd_bank, rd_bin}];

  // The output register doubles as the RAM read register: rj is the next
  // subcarrier to fetch, and a fetch only happens when the output slot frees.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= R_IDLE;
      rb         <= 1'b0;
      rj         <= '0;
      pc         <= '0;
      off        <= '0;
      done       <= 1'b0;
      o_valid    <= 1'b0;
      o_re       <= '0;
      o_im       <= '0;
      o_sc_idx   <= '0;
      o_is_pilot <= 1'b0;
      o_last     <= 1'b0;
    end else begin
      unique case (state)
        R_IDLE: begin
          if (full[rb]) begin
            state <= R_RUN;
            rj    <= '0;
            pc    <= '0;
            done  <= 1'b0;
            off   <= i_pilot_offset;
          end
        end
        R_RUN: begin
          if (rel) begin
            rb <= nrb;
            if (full[nrb]) begin
              o_valid      <= 1'b1;
              {o_re, o_im} <= rd_data;
              o_sc_idx     <= '0;
              o_is_pilot   <= (i_pilot_offset == '0);
              o_last       <= 1'b0;
              rj           <= JW'(1);
              pc           <= pc_inc('0);
              done         <= 1'b0;
              off          <= i_pilot_offset;
            end else begin
              state      <= R_IDLE;
              o_valid    <= 1'b0;
              o_last     <= 1'b0;
              o_is_pilot <= 1'b0;
            end
          end else if (load_ok && !done) begin
            o_valid      <= 1'b1;
            {o_re, o_im} <= rd_data;
            o_sc_idx     <= rj;
            o_is_pilot   <= (pc == off);
            o_last       <= (rj == JW'(NUSED - 1));
            pc           <= pc_inc(pc);
            if (rj == JW'(NUSED - 1)) done <= 1'b1;
            else                      rj   <= rj + 1'b1;
          end
        end
        default: state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rx_demap_data_provider.sv
// tb_rx_demap_data_provider
//   Directed bench for rx_demap_data_provider (NFFT=128, NUSED=72, DW=16,
//   PILOT_SPACING=6). FFT bin k of symbol s carries re = k + 256*s,
//   im = -re. Expected subcarriers are queued in exp_q and checked by a
//   negedge monitor on every accepted output.
module tb_rx_demap_data_provider;
  localparam int NFFT  = 128;
  localparam int NUSED = 72;
  localparam int DW    = 16;
  localparam int PS    = 6;
  localparam int JW    = 7;
  localparam int PW    = 3;
  localparam int EW    = 2 * DW + JW + 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          fft_valid;
  logic          fft_sop;
  logic [DW-1:0] fft_re;
  logic [DW-1:0] fft_im;
  logic [PW-1:0] pilot_off;
  logic          ready;
  logic          o_valid;
  logic [DW-1:0] o_re;
  logic [DW-1:0] o_im;
  logic [JW-1:0] o_sc_idx;
  logic          o_is_pilot;
  logic          o_last;
  logic          o_overflow;
  logic          dbg_state;

  rx_demap_data_provider #(
    .NFFT(NFFT), .NUSED(NUSED), .DW(DW), .PILOT_SPACING(PS)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_fft_valid   (fft_valid),
    .i_fft_sop     (fft_sop),
    .i_fft_re      (fft_re),
    .i_fft_im      (fft_im),
    .i_pilot_offset(pilot_off),
    .i_ready       (ready),
    .o_valid       (o_valid),
    .o_re          (o_re),
    .o_im          (o_im),
    .o_sc_idx      (o_sc_idx),
    .o_is_pilot    (o_is_pilot),
    .o_last        (o_last),
    .o_overflow    (o_overflow),
    .o_dbg_state   (dbg_state)
  );

  int tests   = 0;
  int fails   = 0;
  int out_cnt = 0;
  int ovf_cnt = 0;
  int cnt0;
  int ovf0;
  logic found;
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] mon_e;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- model ----------------
  function automatic int bin_of(input int j);
    return (j < NUSED / 2) ? (NFFT - NUSED / 2 + j) : (j - NUSED / 2 + 1);
  endfunction

  function automatic logic [DW-1:0] re_of(input int s, input int k);
    return DW'(k + 256 * s);
  endfunction

  function automatic logic [DW-1:0] im_of(input int s, input int k);
    return DW'(0) - re_of(s, k);
  endfunction

  task automatic push_symbol(input int s, input int off);
    int b;
    for (int j = 0; j < NUSED; j++) begin
      b = bin_of(j);
      exp_q.push_back({re_of(s, b), im_of(s, b), JW'(j), ((j % PS) == off), (j == NUSED - 1)});
    end
  endtask

  // ---------------- drivers ----------------
  // Called at posedge+1; returns at posedge+1 after the last bin's edge.
  task automatic send_bins(input int s, input int first, input int count);
    for (int k = first; k < first + count; k++) begin
      fft_valid = 1'b1;
      fft_sop   = (k == 0);
      fft_re    = re_of(s, k);
      fft_im    = im_of(s, k);
      @(posedge clk); #1;
    end
    fft_valid = 1'b0;
    fft_sop   = 1'b0;
  endtask

  task automatic wait_drain(input string tag, input int budget);
    @(posedge clk); #1;
    for (int c = 0; c < budget && exp_q.size() != 0; c++) begin
      @(posedge clk); #1;
    end
    check(tag, exp_q.size(), 0);
    repeat (4) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_idx(input int idx, input int budget);
    found = 1'b0;
    for (int c = 0; c < budget && !found; c++) begin
      if (o_valid && o_sc_idx == JW'(idx)) found = 1'b1;
      else begin
        @(posedge clk); #1;
      end
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (rst_n && o_valid && ready) begin
      out_cnt++;
      if (exp_q.size() == 0) begin
        check("sb_extra_valid", o_valid, 0);
      end else begin
        mon_e = exp_q.pop_front();
        check("sb_out", {o_re, o_im, o_sc_idx, o_is_pilot, o_last}, mon_e);
      end
    end
    if (rst_n && o_overflow) ovf_cnt++;
  end

  // ---------------- directed sequence ----------------
  initial begin
    rst_n     = 1'b0;
    fft_valid = 1'b0;
    fft_sop   = 1'b0;
    fft_re    = '0;
    fft_im    = '0;
    pilot_off = '0;
    ready     = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", o_valid, 0);
    check("rst_re", o_re, 0);
    check("rst_im", o_im, 0);
    check("rst_idx", o_sc_idx, 0);
    check("rst_pilot", o_is_pilot, 0);
    check("rst_last", o_last, 0);
    check("rst_ovf", o_overflow, 0);
    check("rst_state", dbg_state, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    ready = 1'b1;

    // basic symbol with latency check
    cnt0 = out_cnt;
    push_symbol(0, 0);
    send_bins(0, 0, NFFT);
    @(negedge clk); check("lat_e0_valid", o_valid, 0);
    @(negedge clk); check("lat_e1_valid", o_valid, 0);
    check("lat_e1_state", dbg_state, 1);
    @(negedge clk); check("lat_e2_valid", o_valid, 1);
    check("lat_e2_idx", o_sc_idx, 0);
    check("lat_e2_re", o_re, 92);
    check("lat_e2_pilot", o_is_pilot, 1);
    wait_drain("basic_drain", 200);
    check("basic_cnt", out_cnt - cnt0, 72);

    // four back-to-back symbols
    cnt0 = out_cnt;
    ovf0 = ovf_cnt;
    for (int s = 1; s <= 4; s++) push_symbol(s, 0);
    for (int s = 1; s <= 4; s++) send_bins(s, 0, NFFT);
    wait_drain("b2b_drain", 200);
    check("b2b_cnt", out_cnt - cnt0, 288);
    check("b2b_ovf", ovf_cnt - ovf0, 0);

    // stall while j=5 is presented
    cnt0 = out_cnt;
    push_symbol(0, 0);
    send_bins(0, 0, NFFT);
    wait_idx(5, 20);
    check("stall_found", found, 1);
    ready = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("stall_valid", o_valid, 1);
      check("stall_re", o_re, 97);
      check("stall_idx", o_sc_idx, 5);
    end
    @(posedge clk); #1;
    ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("resume_idx", o_sc_idx, 6);
    check("resume_re", o_re, 98);
    wait_drain("stall_drain", 200);
    check("stall_cnt", out_cnt - cnt0, 72);

    // overflow: three symbols with ready low
    cnt0 = out_cnt;
    ovf0 = ovf_cnt;
    ready = 1'b0;
    push_symbol(10, 0);
    push_symbol(11, 0);
    send_bins(10, 0, NFFT);
    send_bins(11, 0, NFFT);
    check("ovf_quiet", o_overflow, 0);
    send_bins(12, 0, 1);
    check("ovf_pulse", o_overflow, 1);
    send_bins(12, 1, NFFT - 1);
    check("ovf_stall_valid", o_valid, 1);
    ready = 1'b1;
    wait_drain("ovf_drain", 400);
    check("ovf_out_cnt", out_cnt - cnt0, 144);
    check("ovf_pulses", ovf_cnt - ovf0, 1);

    // pilot offset 3
    cnt0 = out_cnt;
    pilot_off = 3'd3;
    push_symbol(20, 3);
    send_bins(20, 0, NFFT);
    wait_drain("pilot_drain", 200);
    check("pilot_cnt", out_cnt - cnt0, 72);
    pilot_off = '0;

    // resync: sop after 40 samples, then a full symbol
    cnt0 = out_cnt;
    push_symbol(31, 0);
    send_bins(30, 0, 40);
    send_bins(31, 0, NFFT);
    wait_drain("resync_drain", 200);
    check("resync_cnt", out_cnt - cnt0, 72);

    // async reset during the read at j=30
    push_symbol(40, 0);
    send_bins(40, 0, NFFT);
    wait_idx(30, 60);
    check("rr_found", found, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rr_valid", o_valid, 0);
    check("rr_idx", o_sc_idx, 0);
    check("rr_state", dbg_state, 0);
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    cnt0 = out_cnt;
    push_symbol(41, 0);
    send_bins(41, 0, NFFT);
    wait_drain("rr_drain", 200);
    check("rr_cnt", out_cnt - cnt0, 72);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
